// File: rtl/alu_arb_if.sv
// Handshake and ALU bus between two requesters, the arbiter and a shared ALU.
interface alu_arb_if #(
  parameter int REG_WIDTH     = 64,
  parameter int ALU_CTRL_BITS = 5,
  parameter int CNT_WIDTH     = 16
);
  logic                     req0_valid, req1_valid;
  logic                     req0_ready, req1_ready;
  logic [REG_WIDTH-1:0]     req0_rs1, req0_rs2, req0_imm;
  logic [REG_WIDTH-1:0]     req1_rs1, req1_rs2, req1_imm;
  logic [ALU_CTRL_BITS-1:0] req0_ctrl, req1_ctrl;
  logic                     rsp0_valid, rsp1_valid;
  logic                     rsp0_ready, rsp1_ready;
  logic [REG_WIDTH-1:0]     rsp_data;
  logic                     rsp_zero;
  logic [REG_WIDTH-1:0]     alu_rs1, alu_rs2, alu_imm;
  logic [ALU_CTRL_BITS-1:0] alu_ctrl;
  logic [REG_WIDTH-1:0]     alu_out;
  logic                     alu_zero;
  logic [CNT_WIDTH-1:0]     grant_cnt0, grant_cnt1;

  // Arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_rs1, req0_rs2, req0_imm, req0_ctrl,
           req1_rs1, req1_rs2, req1_imm, req1_ctrl, rsp0_ready, rsp1_ready,
           alu_out, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
           alu_rs1, alu_rs2, alu_imm, alu_ctrl, grant_cnt0, grant_cnt1
  );

  // Requesters plus ALU side
  modport master (
    output req0_valid, req1_valid, req0_rs1, req0_rs2, req0_imm, req0_ctrl,
           req1_rs1, req1_rs2, req1_imm, req1_ctrl, rsp0_ready, rsp1_ready,
           alu_out, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
           alu_rs1, alu_rs2, alu_imm, alu_ctrl, grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU with a
// single-entry result stage; one result per cycle when the owner drains.
module alu_arbiter #(
  parameter int REG_WIDTH     = 64,
  parameter int ALU_CTRL_BITS = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_arb_if.slave  bus
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]                    w_req_vld, w_rsp_rdy, w_ready;
  logic [NUM_PORTS-1:0][REG_WIDTH-1:0]     w_rs1, w_rs2, w_imm;
  logic [NUM_PORTS-1:0][ALU_CTRL_BITS-1:0] w_ctrl;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]     r_cnt;

  logic                 r_full, r_owner, r_prio, r_zero;
  logic [REG_WIDTH-1:0] r_data;
  logic                 w_drain, w_acc_ok, w_gnt_any, w_gnt_id, w_accept;

  assign w_req_vld = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_rs1     = {bus.req1_rs1,  bus.req0_rs1};
  assign w_rs2     = {bus.req1_rs2,  bus.req0_rs2};
  assign w_imm     = {bus.req1_imm,  bus.req0_imm};
  assign w_ctrl    = {bus.req1_ctrl, bus.req0_ctrl};

  // rst_n gates the combinational outputs so nothing leaks out while in reset
  assign w_drain   = r_full & w_rsp_rdy[r_owner];
  assign w_acc_ok  = rst_n & (~r_full | w_drain);
  assign w_gnt_any = rst_n & (|w_req_vld);
  assign w_gnt_id  = (&w_req_vld) ? r_prio : w_req_vld[1];
  assign w_accept  = w_acc_ok & w_gnt_any;

  assign bus.alu_rs1  = w_gnt_any ? w_rs1[w_gnt_id]  : '0;
  assign bus.alu_rs2  = w_gnt_any ? w_rs2[w_gnt_id]  : '0;
  assign bus.alu_imm  = w_gnt_any ? w_imm[w_gnt_id]  : '0;
  assign bus.alu_ctrl = w_gnt_any ? w_ctrl[w_gnt_id] : '0;

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.rsp0_valid = r_full & ~r_owner;
  assign bus.rsp1_valid = r_full &  r_owner;
  assign bus.rsp_data   = r_data;
  assign bus.rsp_zero   = r_zero;
  assign bus.grant_cnt0 = r_cnt[0];
  assign bus.grant_cnt1 = r_cnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_full  <= 1'b1;
      r_owner <= w_gnt_id;
      r_prio  <= ~w_gnt_id;
      r_data  <= bus.alu_out;
      r_zero  <= bus.alu_zero;
    end else if (w_drain) begin
      r_full  <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_ready[gi] = w_accept & (w_gnt_id == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_cnt[gi] <= '0;
      else if (w_ready[gi]) r_cnt[gi] <= r_cnt[gi] + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a transaction-level model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_arb_if #(.REG_WIDTH(64), .ALU_CTRL_BITS(5), .CNT_WIDTH(16)) bus ();
  alu_arb_if #(.REG_WIDTH(64), .ALU_CTRL_BITS(5), .CNT_WIDTH(2))  bus2 ();

  alu_arbiter #(.REG_WIDTH(64), .ALU_CTRL_BITS(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  alu_arbiter #(.REG_WIDTH(64), .ALU_CTRL_BITS(5), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // Reference ALU; codes 6 and up give an arbitrary but repeatable value
  function automatic logic [63:0] alu_f(logic [4:0] c, logic [63:0] a, logic [63:0] b,
                                        logic [63:0] imm);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a + imm;
      default: return {a[31:0], b[63:32]} ^ imm;
    endcase
  endfunction

  always_comb begin
    logic [63:0] t;
    t = alu_f(bus.alu_ctrl, bus.alu_rs1, bus.alu_rs2, bus.alu_imm);
    bus.alu_out  = t;
    bus.alu_zero = (t == 64'd0);
  end

  always_comb begin
    logic [63:0] t2;
    t2 = alu_f(bus2.alu_ctrl, bus2.alu_rs1, bus2.alu_rs2, bus2.alu_imm);
    bus2.alu_out  = t2;
    bus2.alu_zero = (t2 == 64'd0);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(bit v0, bit v1, logic [4:0] c0, logic [63:0] a0, logic [63:0] b0,
                     logic [4:0] c1, logic [63:0] a1, logic [63:0] b1, bit rr0, bit rr1);
    bus.req0_valid = v0; bus.req0_ctrl = c0; bus.req0_rs1 = a0; bus.req0_rs2 = b0;
    bus.req1_valid = v1; bus.req1_ctrl = c1; bus.req1_rs1 = a1; bus.req1_rs2 = b1;
    bus.req0_imm = '0;   bus.req1_imm = '0;
    bus.rsp0_ready = rr0; bus.rsp1_ready = rr1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drv(1, 1, 5'd0, 64'd3, 64'd4, 5'd0, 64'd5, 64'd6, 1, 1);
    #1;
    chk("rst_ready0", 64'(bus.req0_ready), 0);
    chk("rst_ready1", 64'(bus.req1_ready), 0);
    chk("rst_rsp_valid", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rst_alu_rs1", bus.alu_rs1, 0);
    chk("rst_alu_ctrl", 64'(bus.alu_ctrl), 0);
    chk("rst_cnt", {32'(bus.grant_cnt1), 32'(bus.grant_cnt0)}, 0);
    chk("rst_data", {bus.rsp_data[62:0], bus.rsp_zero}, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v0, v1;
    logic [4:0] c0; logic [63:0] a0, b0;
    logic [4:0] c1; logic [63:0] a1, b1;
    bit rr0, rr1;
    bit er0, er1;       // expected req ready this cycle
    bit ev0, ev1;       // expected rsp valid after the edge
    logic [63:0] ed; bit ez;
  } vec_t;

  vec_t vecs[11];

  task automatic apply_vec(int i, vec_t v);
    @(negedge clk);
    drv(v.v0, v.v1, v.c0, v.a0, v.b0, v.c1, v.a1, v.b1, v.rr0, v.rr1);
    #1;
    chk($sformatf("vec%0d_ready0", i), 64'(bus.req0_ready), 64'(v.er0));
    chk($sformatf("vec%0d_ready1", i), 64'(bus.req1_ready), 64'(v.er1));
    if (!v.v0 && !v.v1) chk($sformatf("vec%0d_alu_idle", i), bus.alu_rs1 | bus.alu_rs2, 0);
    if (v.er0) chk($sformatf("vec%0d_alu_rs1", i), bus.alu_rs1, v.a0);
    if (v.er1) chk($sformatf("vec%0d_alu_rs2", i), bus.alu_rs2, v.b1);
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_rsp0_valid", i), 64'(bus.rsp0_valid), 64'(v.ev0));
    chk($sformatf("vec%0d_rsp1_valid", i), 64'(bus.rsp1_valid), 64'(v.ev1));
    if (v.ev0 || v.ev1) begin
      chk($sformatf("vec%0d_data", i), bus.rsp_data, v.ed);
      chk($sformatf("vec%0d_zero", i), 64'(bus.rsp_zero), 64'(v.ez));
    end
  endtask

  // Transaction-level model state for the random phase
  typedef struct { bit owner; logic [63:0] data; bit zero; } res_t;
  res_t        held[$];
  bit          m_prio;
  logic [15:0] m_cnt[2];
  bit          pend[2];
  logic [63:0] p_rs1[2], p_rs2[2], p_imm[2];
  logic [4:0]  p_ctrl[2];

  task automatic random_phase(int cycles);
    held.delete(); m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0; pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < cycles; c++) begin
      bit rr[2];
      bit drain, ok, any;
      int g;
      res_t r;
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 3) != 0)) begin
          pend[n]   = 1;
          p_rs1[n]  = ($urandom_range(0, 3) == 0) ? 64'd17 : {$urandom, $urandom};
          p_rs2[n]  = ($urandom_range(0, 3) == 0) ? 64'd17 : {$urandom, $urandom};
          p_imm[n]  = {$urandom, $urandom};
          p_ctrl[n] = 5'($urandom_range(0, 7));
        end
        rr[n] = ($urandom_range(0, 4) != 0);
      end
      bus.req0_valid = pend[0]; bus.req0_rs1 = p_rs1[0]; bus.req0_rs2 = p_rs2[0];
      bus.req0_imm = p_imm[0];  bus.req0_ctrl = p_ctrl[0];
      bus.req1_valid = pend[1]; bus.req1_rs1 = p_rs1[1]; bus.req1_rs2 = p_rs2[1];
      bus.req1_imm = p_imm[1];  bus.req1_ctrl = p_ctrl[1];
      bus.rsp0_ready = rr[0];   bus.rsp1_ready = rr[1];
      #1;
      drain = (held.size() > 0) && rr[held[0].owner];
      ok    = (held.size() == 0) || drain;
      any   = pend[0] || pend[1];
      g     = (pend[0] && pend[1]) ? int'(m_prio) : (pend[1] ? 1 : 0);
      chk("rnd_ready0", 64'(bus.req0_ready), 64'(ok && any && g == 0));
      chk("rnd_ready1", 64'(bus.req1_ready), 64'(ok && any && g == 1));
      chk("rnd_rsp0_valid", 64'(bus.rsp0_valid), 64'(held.size() > 0 && !held[0].owner));
      chk("rnd_rsp1_valid", 64'(bus.rsp1_valid), 64'(held.size() > 0 && held[0].owner));
      if (held.size() > 0) begin
        chk("rnd_data", bus.rsp_data, held[0].data);
        chk("rnd_zero", 64'(bus.rsp_zero), 64'(held[0].zero));
      end
      chk("rnd_cnt0", 64'(bus.grant_cnt0), 64'(m_cnt[0]));
      chk("rnd_cnt1", 64'(bus.grant_cnt1), 64'(m_cnt[1]));
      if (any) begin
        chk("rnd_alu_rs1", bus.alu_rs1, p_rs1[g]);
        chk("rnd_alu_ctrl", 64'(bus.alu_ctrl), 64'(p_ctrl[g]));
      end
      if (drain) void'(held.pop_front());
      if (ok && any) begin
        r.owner = (g == 1);
        r.data  = alu_f(p_ctrl[g], p_rs1[g], p_rs2[g], p_imm[g]);
        r.zero  = (r.data == 64'd0);
        held.push_back(r);
        m_prio   = (g == 0);
        m_cnt[g] = m_cnt[g] + 16'd1;
        pend[g]  = 0;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus2.req0_valid = 0; bus2.req1_valid = 0; bus2.rsp0_ready = 1; bus2.rsp1_ready = 1;
    bus2.req0_rs1 = 64'd1; bus2.req0_rs2 = 64'd1; bus2.req0_imm = 0; bus2.req0_ctrl = 0;
    bus2.req1_rs1 = 0; bus2.req1_rs2 = 0; bus2.req1_imm = 0; bus2.req1_ctrl = 0;

    //           v0 v1 c0 a0       b0       c1 a1       b1       rr0 rr1 er0 er1 ev0 ev1 ed       ez
    vecs[0]  = '{1, 1, 0, 64'd1,   64'd2,   0, 64'd10,  64'd20,  1, 1, 1, 0, 1, 0, 64'd3,    0};
    vecs[1]  = '{1, 1, 0, 64'd1,   64'd2,   0, 64'd10,  64'd20,  1, 1, 0, 1, 0, 1, 64'd30,   0};
    vecs[2]  = '{1, 1, 0, 64'd1,   64'd2,   0, 64'd10,  64'd20,  1, 1, 1, 0, 1, 0, 64'd3,    0};
    vecs[3]  = '{1, 1, 0, 64'd1,   64'd2,   0, 64'd10,  64'd20,  1, 1, 0, 1, 0, 1, 64'd30,   0};
    vecs[4]  = '{0, 0, 0, 64'd0,   64'd0,   0, 64'd0,   64'd0,   1, 1, 0, 0, 0, 0, 64'd0,    0};
    vecs[5]  = '{1, 0, 0, 64'd5,   64'd7,   0, 64'd0,   64'd0,   1, 1, 1, 0, 1, 0, 64'd12,   0};
    vecs[6]  = '{1, 0, 1, 64'd9,   64'd9,   0, 64'd0,   64'd0,   1, 1, 1, 0, 1, 0, 64'd0,    1};
    vecs[7]  = '{0, 1, 0, 64'd0,   64'd0,   4, 64'h0F0F, 64'hFFFF, 1, 0, 0, 1, 0, 1, 64'hF0F0, 0};
    vecs[8]  = '{1, 0, 2, 64'hFF00, 64'h0FF0, 0, 64'd0, 64'd0,   1, 0, 0, 0, 0, 1, 64'hF0F0, 0};
    vecs[9]  = '{1, 0, 2, 64'hFF00, 64'h0FF0, 0, 64'd0, 64'd0,   1, 1, 1, 0, 1, 0, 64'h0F00, 0};
    vecs[10] = '{0, 0, 0, 64'd0,   64'd0,   0, 64'd0,   64'd0,   1, 1, 0, 0, 0, 0, 64'd0,    0};

    do_reset();
    for (int i = 0; i < 11; i++) apply_vec(i, vecs[i]);
    chk("tbl_cnt0", 64'(bus.grant_cnt0), 64'd5);
    chk("tbl_cnt1", 64'(bus.grant_cnt1), 64'd3);

    // Single add from reset, latency and counter
    do_reset();
    @(negedge clk);
    drv(1, 0, 0, 64'd5, 64'd7, 0, 0, 0, 1, 1);
    #1 chk("single_ready0", 64'(bus.req0_ready), 1);
    @(posedge clk); #1;
    chk("single_rsp0_valid", 64'(bus.rsp0_valid), 1);
    chk("single_data", bus.rsp_data, 64'd12);
    chk("single_zero", 64'(bus.rsp_zero), 0);
    chk("single_cnt0", 64'(bus.grant_cnt0), 1);

    // Backpressure on port 1 for three cycles while port 0 waits
    do_reset();
    @(negedge clk);
    drv(0, 1, 0, 0, 0, 0, 64'd2, 64'd3, 0, 0);
    #1 chk("bp_ready1", 64'(bus.req1_ready), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drv(1, 0, 0, 64'd40, 64'd2, 0, 0, 0, 1, 0);
      #1;
      chk("bp_ready0_blocked", 64'(bus.req0_ready), 0);
      chk("bp_rsp1_valid", 64'(bus.rsp1_valid), 1);
      chk("bp_data_held", bus.rsp_data, 64'd5);
    end
    @(negedge clk);
    bus.rsp1_ready = 1;
    #1 chk("bp_ready0_release", 64'(bus.req0_ready), 1);
    @(posedge clk); #1;
    chk("bp_rsp0_valid", 64'(bus.rsp0_valid), 1);
    chk("bp_rsp1_cleared", 64'(bus.rsp1_valid), 0);
    chk("bp_data_new", bus.rsp_data, 64'd42);

    // Reset asserted mid-cycle while port 1 holds a result
    do_reset();
    @(negedge clk);
    drv(0, 1, 0, 0, 0, 0, 64'd4, 64'd4, 0, 0);
    @(posedge clk); #1;
    chk("mid_rsp1_valid", 64'(bus.rsp1_valid), 1);
    @(negedge clk);
    drv(1, 1, 0, 64'd1, 64'd2, 0, 64'd6, 64'd6, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp1_dropped", 64'(bus.rsp1_valid), 0);
    chk("mid_cnt1", 64'(bus.grant_cnt1), 0);
    chk("mid_ready_low", {62'd0, bus.req1_ready, bus.req0_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_grant0", 64'(bus.req0_ready), 1);
    chk("mid_no_grant1", 64'(bus.req1_ready), 0);
    @(posedge clk); #1;
    chk("mid_rsp0_data", bus.rsp_data, 64'd3);

    // Narrow counter wrap on the second instance
    do_reset();
    @(negedge clk);
    bus2.req0_valid = 1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] expc;
      expc = 2'(k + 1);
      @(posedge clk); #1;
      chk($sformatf("wrap_cnt0_%0d", k), 64'(bus2.grant_cnt0), 64'(expc));
    end
    @(negedge clk);
    bus2.req0_valid = 0;

    do_reset();
    random_phase(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter REG_WIDTH, default 64, SHALL set operand and result width.
REQ-002 Parameter ALU_CTRL_BITS, default 5, SHALL set ALU control code width.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set per-port grant counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 reqN_valid  input  1  (N=0,1) SHALL flag that requester N presents an operation.
REQ-007 reqN_ready  output  1  SHALL flag acceptance of requester N's operation this cycle.
REQ-008 reqN_rs1, reqN_rs2, reqN_imm  input  REG_WIDTH each  SHALL carry requester N's operands.
REQ-009 reqN_ctrl  input  ALU_CTRL_BITS  SHALL carry requester N's ALU control code.
REQ-010 rspN_valid  output  1  SHALL flag that a result for requester N is held.
REQ-011 rspN_ready  input  1  SHALL flag that requester N consumes its result this cycle.
REQ-012 rsp_data  output  REG_WIDTH, rsp_zero  output  1  SHALL carry the held result and zero flag, shared by both ports.
REQ-013 alu_rs1, alu_rs2, alu_imm  output  REG_WIDTH, alu_ctrl  output  ALU_CTRL_BITS  SHALL drive the shared ALU.
REQ-014 alu_out  input  REG_WIDTH, alu_zero  input  1  SHALL return the ALU's combinational result.
REQ-015 grant_cnt0, grant_cnt1  output  CNT_WIDTH  SHALL count accepted operations per port.

Function
REQ-016 Output stage state SHALL be EMPTY or FULL; FULL holds one result register, zero flag and owner id.
REQ-017 Accept is possible SHALL be true when state is EMPTY, or FULL and rsp[owner]_ready is 1.
REQ-018 Arbitration: exactly one valid requester SHALL be granted; both valid SHALL grant the port selected by 1-bit pointer prio.
REQ-019 reqN_ready SHALL equal accept-possible AND grant to N; at most one reqN_ready high per cycle.
REQ-020 On each accept, prio SHALL update to the non-granted port; prio SHALL hold when no accept occurs.
REQ-021 ALU outputs SHALL combinationally pass the granted requester's operands and ctrl unmodified; with no grant they SHALL be all-zero.
REQ-022 On accept edge: result register <= alu_out, zero flag <= alu_zero, owner <= N, state <= FULL.
REQ-023 Latency SHALL be exactly 1 cycle: rspN_valid high the cycle after the accepting edge.
REQ-024 rspN_valid SHALL equal (state FULL AND owner==N); rsp_data and rsp_zero SHALL be stable while valid and not consumed.
REQ-025 Drain without accept SHALL set state EMPTY; simultaneous drain and accept SHALL load the new result and remain FULL (back-to-back throughput 1/cycle).
REQ-026 While FULL and owner's rsp_ready is 0, both reqN_ready SHALL be 0 and the held result SHALL not change.
REQ-027 A request not granted SHALL remain pending; requesters SHALL hold valid and payload until ready, and valid SHALL not depend on ready.
REQ-028 grant_cntN SHALL increment by 1 on each accept of port N and wrap from all-ones to 0.
REQ-029 Undefined ALU result (unsupported ctrl code) SHALL be captured and returned unmodified; no error is raised.

Reset
REQ-030 rst_n low SHALL immediately force state EMPTY, prio 0, owner 0, result register 0, zero flag 0, grant counters 0.
REQ-031 During reset all reqN_ready, rspN_valid SHALL be 0 and ALU outputs all-zero; a result pending when reset asserts SHALL be discarded.
REQ-032 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Single port: req0 add rs1=5, rs2=7 (ctrl 00000), rsp0_ready=1 -> req0_ready=1, next cycle rsp0_valid=1, rsp_data=12, rsp_zero=0, grant_cnt0=1.
REQ-034 Contention: both valid every cycle after reset, rsp ready=1 -> grants alternate 0,1,0,1; four results returned in order, one per cycle.
REQ-035 Backpressure: result held for port 1, rsp1_ready=0 for 3 cycles while req0 valid -> req0_ready=0, rsp_data unchanged; rsp1_ready=1 -> drain and req0 accepted same cycle.
REQ-036 Zero flag: sub rs1=9, rs2=9 (ctrl 00001) -> rsp_data=0, rsp_zero=1.
REQ-037 Reset mid-operation: FULL with owner 1, rst_n pulsed low mid-cycle -> rsp1_valid=0 immediately, counters 0, next grant to port 0 under contention.
REQ-038 Counter wrap: CNT_WIDTH=2, five port-0 accepts -> grant_cnt0 sequence 1,2,3,0,1.
